// File: rtl/regread_port_arbiter_pkg.sv
// Shared constants and types for the register-file read-port arbiter.
package regread_port_arbiter_pkg;

  localparam logic REQ_BR  = 1'b0;
  localparam logic REQ_ALU = 1'b1;

  localparam int DEF_W = 5;
  localparam int DEF_D = 32;

  typedef struct packed {
    logic valid;
    logic id;
  } resp_tag_t;

endpackage

// File: rtl/regread_port_arbiter_rr_arb2.sv
// Two-way grant logic: round-robin on last_grant, or fixed requester-0 priority.
module rr_arb2
  import regread_port_arbiter_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       prio_mode,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      if (prio_mode || last_grant == REQ_ALU) grant = 2'b01;
      else                                    grant = 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/regread_port_arbiter.sv
// Shares one register-file read port between the branch unit and ALU operand fetch.
// Build option BRANCH_PRIORITY_EN: requester 0 wins every conflict (default: round-robin).
module regread_port_arbiter
  import regread_port_arbiter_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int D     = DEF_D,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_addr,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_addr,
  output logic             req1_ready,
  output logic             rf_ren,
  output logic [W-1:0]     rf_raddr,
  input  logic [D-1:0]     rf_rdata,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [D-1:0]     resp_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] conflict_cnt
);

`ifdef BRANCH_PRIORITY_EN
  localparam logic PRIO_MODE = 1'b1;
`else
  localparam logic PRIO_MODE = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic       last_grant;
  logic [1:0] arb_grant;
  logic [1:0] grant;
  logic       grant_any;
  resp_tag_t  s1_tag;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .prio_mode  (PRIO_MODE),
    .grant      (arb_grant)
  );

  // No grants escape while reset is held, so every output reads 0 in reset.
  assign grant     = rst_n ? arb_grant : 2'b00;
  assign grant_any = grant[0] | grant[1];

  always_comb begin
    req0_ready = grant[0];
    req1_ready = grant[1];
    rf_ren     = grant_any;
    rf_raddr   = '0;
    if (grant[0])      rf_raddr = req0_addr;
    else if (grant[1]) rf_raddr = req1_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_ALU;
    end else if (grant_any) begin
      last_grant <= grant[1];
    end
  end

  // Stage 1 tags the grant; stage 2 captures rf_rdata, which arrives one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tag      <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_data   <= '0;
    end else begin
      s1_tag.valid <= grant_any;
      s1_tag.id    <= grant[1];
      resp0_valid  <= s1_tag.valid && (s1_tag.id == REQ_BR);
      resp1_valid  <= s1_tag.valid && (s1_tag.id == REQ_ALU);
      if (s1_tag.valid) resp_data <= rf_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (cnt_clr) begin
      conflict_cnt <= '0;
    end else if (req0_valid && req1_valid && conflict_cnt != CNT_MAX) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regread_port_arbiter.sv
// Directed bench for regread_port_arbiter (CNT_W=4), including a small register-file model.
module tb_regread_port_arbiter;

`ifdef BRANCH_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic        req0_ready, req1_ready;
  logic        rf_ren;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp_data;
  logic        cnt_clr;
  logic [3:0]  conflict_cnt;

  int checks   = 0;
  int failures = 0;

  regread_port_arbiter #(.W(5), .D(32), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_addr    (req0_addr),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_addr    (req1_addr),
    .req1_ready   (req1_ready),
    .rf_ren       (rf_ren),
    .rf_raddr     (rf_raddr),
    .rf_rdata     (rf_rdata),
    .resp0_valid  (resp0_valid),
    .resp1_valid  (resp1_valid),
    .resp_data    (resp_data),
    .cnt_clr      (cnt_clr),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_value(input logic [4:0] a);
    return (a == 5'd5) ? 32'hDEADBEEF : (32'hC0DE0000 | {27'd0, a});
  endfunction

  // Register file stand-in: data for the read address appears the cycle after rf_ren.
  initial rf_rdata = 32'h0;
  always @(posedge clk) begin
    if (rf_ren) rf_rdata <= rf_value(rf_raddr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic v1, input logic [4:0] a1);
    req0_valid = v0; req0_addr = a0;
    req1_valid = v1; req1_addr = a1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    cnt_clr = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 5'd7);
    #3;
    chk("rst_req0_ready", {31'd0, req0_ready}, 0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 0);
    chk("rst_rf_ren", {31'd0, rf_ren}, 0);
    chk("rst_rf_raddr", {27'd0, rf_raddr}, 0);
    chk("rst_resp_valids", {30'd0, resp1_valid, resp0_valid}, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_conflict_cnt", {28'd0, conflict_cnt}, 0);
    do_reset();

    // Single request from requester 0
    next_cycle(); drive(1'b1, 5'd5, 1'b0, 5'd0); #1;
    chk("single_ready0", {31'd0, req0_ready}, 1);
    chk("single_ready1", {31'd0, req1_ready}, 0);
    chk("single_ren", {31'd0, rf_ren}, 1);
    chk("single_raddr", {27'd0, rf_raddr}, 5);
    next_cycle(); drive(1'b0, 5'd0, 1'b0, 5'd0); #1;
    chk("single_idle_ren", {31'd0, rf_ren}, 0);
    chk("single_idle_raddr", {27'd0, rf_raddr}, 0);
    chk("single_c2_resp0", {31'd0, resp0_valid}, 0);
    next_cycle(); #1;
    chk("single_c3_resp0", {31'd0, resp0_valid}, 1);
    chk("single_c3_resp1", {31'd0, resp1_valid}, 0);
    chk("single_c3_data", resp_data, 32'hDEADBEEF);
    next_cycle(); #1;
    chk("single_c4_resp0", {31'd0, resp0_valid}, 0);
    chk("single_c4_hold", resp_data, 32'hDEADBEEF);

    // Four conflict cycles, responses drain two cycles later
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic g;
      logic r;
      next_cycle();
      if (i < 4) drive(1'b1, 5'd3, 1'b1, 5'd7);
      else       drive(1'b0, 5'd0, 1'b0, 5'd0);
      #1;
      g = PRIO ? 1'b0 : logic'(i % 2);
      r = PRIO ? 1'b0 : logic'((i - 2) % 2);
      if (i < 4) begin
        chk($sformatf("conf_ready0_%0d", i), {31'd0, req0_ready}, {31'd0, ~g});
        chk($sformatf("conf_ready1_%0d", i), {31'd0, req1_ready}, {31'd0, g});
        chk($sformatf("conf_raddr_%0d", i), {27'd0, rf_raddr}, g ? 32'd7 : 32'd3);
      end
      if (i >= 2) begin
        chk($sformatf("conf_resp0_%0d", i), {31'd0, resp0_valid}, {31'd0, ~r});
        chk($sformatf("conf_resp1_%0d", i), {31'd0, resp1_valid}, {31'd0, r});
        chk($sformatf("conf_data_%0d", i), resp_data, r ? 32'hC0DE0007 : 32'hC0DE0003);
      end
    end
    chk("conf_cnt", {28'd0, conflict_cnt}, 4);
    next_cycle(); #1;
    chk("conf_drained", {30'd0, resp1_valid, resp0_valid}, 0);

    // Requester 1 held while requester 0 pulses
    do_reset();
    next_cycle(); drive(1'b1, 5'd2, 1'b1, 5'd9); #1;
    chk("stall_c1_r0", {31'd0, req0_ready}, 1);
    chk("stall_c1_r1", {31'd0, req1_ready}, 0);
    chk("stall_c1_raddr", {27'd0, rf_raddr}, 2);
    next_cycle(); drive(1'b0, 5'd0, 1'b1, 5'd9); #1;
    chk("stall_c2_r1", {31'd0, req1_ready}, 1);
    chk("stall_c2_raddr", {27'd0, rf_raddr}, 9);
    next_cycle(); drive(1'b1, 5'd2, 1'b0, 5'd0); #1;
    chk("stall_c3_r0", {31'd0, req0_ready}, 1);
    chk("stall_c3_resp", {30'd0, resp1_valid, resp0_valid}, 32'd1);
    chk("stall_c3_data", resp_data, 32'hC0DE0002);
    next_cycle(); drive(1'b0, 5'd0, 1'b0, 5'd0); #1;
    chk("stall_c4_resp", {30'd0, resp1_valid, resp0_valid}, 32'd2);
    chk("stall_c4_data", resp_data, 32'hC0DE0009);
    next_cycle(); #1;
    chk("stall_c5_resp", {30'd0, resp1_valid, resp0_valid}, 32'd1);
    chk("stall_c5_data", resp_data, 32'hC0DE0002);
    next_cycle(); #1;
    chk("stall_c6_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("stall_cnt", {28'd0, conflict_cnt}, 1);

    // Counter saturation and clear
    do_reset();
    for (int i = 0; i < 20; i++) begin
      next_cycle(); drive(1'b1, 5'd1, 1'b1, 5'd2);
      if (i == 15) begin
        #1 chk("sat_at_15", {28'd0, conflict_cnt}, 15);
      end
    end
    next_cycle(); cnt_clr = 1'b1; #1;
    chk("sat_20", {28'd0, conflict_cnt}, 15);
    next_cycle(); cnt_clr = 1'b0; #1;
    chk("clr_priority", {28'd0, conflict_cnt}, 0);
    next_cycle(); drive(1'b0, 5'd0, 1'b0, 5'd0); #1;
    chk("after_clr_inc", {28'd0, conflict_cnt}, 1);

    // Reset while a response is in flight
    do_reset();
    next_cycle(); drive(1'b1, 5'd4, 1'b0, 5'd0); #1;
    chk("rstmid_grant", {31'd0, req0_ready}, 1);
    next_cycle(); drive(1'b0, 5'd0, 1'b0, 5'd0); rst_n = 1'b0; #1;
    chk("rstmid_resp", {30'd0, resp1_valid, resp0_valid}, 0);
    chk("rstmid_data", resp_data, 0);
    chk("rstmid_ren", {31'd0, rf_ren}, 0);
    next_cycle(); rst_n = 1'b1; #1;
    chk("rstmid_n2_resp", {30'd0, resp1_valid, resp0_valid}, 0);
    next_cycle(); drive(1'b1, 5'd3, 1'b1, 5'd7); #1;
    chk("rstmid_n3_resp", {30'd0, resp1_valid, resp0_valid}, 0);
    chk("rstmid_tie_r0", {31'd0, req0_ready}, 1);
    chk("rstmid_tie_r1", {31'd0, req1_ready}, 0);
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regread_port_arbiter.md
Name: regread_port_arbiter

Overview:
- Shares the single register-file read-address port between two requesters and sequences the resulting reads.
- Requester 0 is the branch-compare unit; requester 1 is the ALU operand fetch.
- Grants one read per cycle, drives the port's address select, and returns tagged read data two cycles after the grant.
- Sits between the decode stage and the register file, replacing static select-by-isBranch muxing.

Parameters:
W, 5, register address width
D, 32, register data width
CNT_W, 16, width of the conflict counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  branch unit read request
req0_addr  input  W  branch unit register address
req0_ready  output  1  grant to requester 0 this cycle
req1_valid  input  1  ALU read request
req1_addr  input  W  ALU register address
req1_ready  output  1  grant to requester 1 this cycle
rf_ren  output  1  register file read enable
rf_raddr  output  W  register file read address
rf_rdata  input  D  register file data, valid 1 cycle after rf_ren
resp0_valid  output  1  resp_data belongs to requester 0
resp1_valid  output  1  resp_data belongs to requester 1
resp_data  output  D  registered read data
cnt_clr  input  1  synchronous clear of conflict_cnt
conflict_cnt  output  CNT_W  cycles in which both requesters were valid

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. All state clears immediately on rst_n=0.
- Reset values: req0_ready=0, req1_ready=0, rf_ren=0, rf_raddr=0, resp0_valid=0, resp1_valid=0, resp_data=0, conflict_cnt=0, last_grant=1 (so requester 0 wins the first tie).
- Grant (cycle N), combinational from the current inputs and last_grant:
  - Exactly one valid requester: it is granted.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant, rf_ren=0, rf_raddr holds 0.
- On a grant in cycle N:
  - reqK_ready=1, rf_ren=1, rf_raddr=reqK_addr.
  - last_grant<=K at the clock edge.
- Requester contract: reqK_addr stays stable while reqK_valid=1 and reqK_ready=0. A requester may drop valid without a grant.
- Pipeline:
  - Stage 1 registers {valid, id} at the end of cycle N.
  - In cycle N+1, rf_rdata is valid; stage 2 registers resp_data<=rf_rdata and sets respK_valid=1 for cycle N+2 only.
  - Latency is exactly 2 cycles. Throughput is 1 grant per cycle. Responses are never back-pressured.
- Back-to-back grants produce back-to-back responses in grant order; ids are never reordered.
- When no response is in flight, resp0_valid and resp1_valid are both 0 and resp_data holds its last value.
- Conflict counter:
  - Increments by 1 on each cycle with req0_valid & req1_valid.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr has priority over increment and forces 0 at the next edge.
- Reset mid-operation: in-flight stage 1 and stage 2 entries are discarded, so no respK_valid pulse follows reset. last_grant returns to 1.
- Register address 0 is treated like any other address; the register file supplies its value.

Optional Feature:
- Macro: BRANCH_PRIORITY_EN.
- Defined: requester 0 wins every conflict; last_grant still updates but is ignored for arbitration; requester 1 may starve.
- Undefined: round-robin as above.
- Counter and pipeline behaviour are identical in both builds.

Decomposition:
- Shared package:
  - Requester id constants REQ_BR=0, REQ_ALU=1.
  - Response tag typedef {valid, id}.
  - Default widths W=5, D=32.
- Sub-module rr_arb2: 2-way round-robin grant logic. Inputs: two valids, last_grant, priority mode. Outputs: one-hot grant. Purely combinational; last_grant register stays in the parent.

Test Plan:
- Single request: req0 valid with addr=5 in cycle 1 -> req0_ready=1 and rf_raddr=5 in cycle 1; rf_rdata=0xDEADBEEF in cycle 2 -> resp0_valid=1, resp_data=0xDEADBEEF in cycle 3 only.
- Conflict round-robin: both valid for 4 cycles (addr0=3, addr1=7) -> grants 0,1,0,1; responses tagged 0,1,0,1 two cycles later; conflict_cnt=4.
- Priority build (BRANCH_PRIORITY_EN): both valid for 4 cycles -> four grants to requester 0, req1_ready stays 0, conflict_cnt=4.
- Stalled requester: req1 valid, req0 valid alternating cycles -> req1_addr held stable until req1_ready=1; no lost or duplicated response.
- Counter saturation and clear with CNT_W=4: 20 conflict cycles -> conflict_cnt=15; cnt_clr together with conflict -> 0 next cycle.
- Reset mid-flight: grant in cycle N, rst_n low during cycle N+1 -> no respK_valid pulse; all outputs 0; first tie after release goes to requester 0.
